// File: rtl/ex_stage_if.sv
// ID/EX -> EX bus and EX -> EX/MEM / forwarding bus for the execute stage.
// Latency: wires only; no storage in the interface.
// Backpressure: ex_stall_req from the slave holds the master (ID/EX) contents.
//
// Shared encodings for the execute stage live here so that every user of the
// interface sees the same operation and class codes.
//
// Signals (master = ID/EX side, slave = ex_stage):
//   ex_valid        master->slave  instruction valid
//   ex_rtlop_i      master->slave  operation code
//   ex_rtltype_i    master->slave  operation class
//   ex_pc_i         master->slave  instruction PC
//   ex_src1_i/2_i   master->slave  operands
//   ex_gprs_waddr_i master->slave  destination register
//   ex_stall_req    slave->master  hold ID/EX and upstream this cycle
//   ex_valid_o      slave->master  result valid to EX/MEM
//   ex_pc_o         slave->master  PC passthrough
//   ex_gprs_we_o    slave->master  register write enable (also forwarding)
//   ex_gprs_waddr_o slave->master  destination register passthrough
//   ex_gprs_wdata_o slave->master  result
`ifndef EX_STAGE_DEFS_SVH
`define EX_STAGE_DEFS_SVH

`define DATA_BUS        31:0
`define REG_BUS         4:0
`define RTLOP_BUS       4:0
`define RTLTYPE_BUS     1:0

`define REG_X0          5'd0

`define RTLTYPE_NONE    2'd0
`define RTLTYPE_ARICH   2'd1
`define RTLTYPE_MULDIV  2'd2

`define RTLOP_ADD       5'd0
`define RTLOP_SUB       5'd1
`define RTLOP_AND       5'd2
`define RTLOP_OR        5'd3
`define RTLOP_XOR       5'd4
`define RTLOP_SLL       5'd5
`define RTLOP_SRL       5'd6
`define RTLOP_SRA       5'd7
`define RTLOP_SLT       5'd8
`define RTLOP_SLTU      5'd9
`define RTLOP_MUL       5'd10
`define RTLOP_MULH      5'd11
`define RTLOP_MULHSU    5'd12
`define RTLOP_MULHU     5'd13
`define RTLOP_DIV       5'd14
`define RTLOP_DIVU      5'd15
`define RTLOP_REM       5'd16
`define RTLOP_REMU      5'd17

`endif

interface ex_stage_if;
    logic                 ex_valid;
    logic [`RTLOP_BUS]    ex_rtlop_i;
    logic [`RTLTYPE_BUS]  ex_rtltype_i;
    logic [`DATA_BUS]     ex_pc_i;
    logic [`DATA_BUS]     ex_src1_i;
    logic [`DATA_BUS]     ex_src2_i;
    logic [`REG_BUS]      ex_gprs_waddr_i;

    logic                 ex_stall_req;
    logic                 ex_valid_o;
    logic [`DATA_BUS]     ex_pc_o;
    logic                 ex_gprs_we_o;
    logic [`REG_BUS]      ex_gprs_waddr_o;
    logic [`DATA_BUS]     ex_gprs_wdata_o;

    modport master (
        output ex_valid, ex_rtlop_i, ex_rtltype_i, ex_pc_i,
               ex_src1_i, ex_src2_i, ex_gprs_waddr_i,
        input  ex_stall_req, ex_valid_o, ex_pc_o,
               ex_gprs_we_o, ex_gprs_waddr_o, ex_gprs_wdata_o
    );

    modport slave (
        input  ex_valid, ex_rtlop_i, ex_rtltype_i, ex_pc_i,
               ex_src1_i, ex_src2_i, ex_gprs_waddr_i,
        output ex_stall_req, ex_valid_o, ex_pc_o,
               ex_gprs_we_o, ex_gprs_waddr_o, ex_gprs_wdata_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/multiplier plus an iterative restoring divider.
// Latency: ALU/MUL same cycle; divide 34 cycles (33 stalled); div-by-zero/overflow 2 cycles.
// Backpressure: raises ex_stall_req while the divider owns the instruction; flush/rst abort.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   flush pipeline flush (same signal that clears ID/EX)
//   bus   ex_stage_if.slave: ID/EX operands in, EX/MEM result and stall request out
module ex_stage #(
    parameter int XLEN = 32    // datapath width, must match the DATA_BUS width
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    ex_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand / decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      shamt;
    logic            kill;
    logic            is_arith;
    logic            arith_legal;
    logic            is_div_op;
    logic            div_signed;
    logic            div_is_rem;
    logic            div_req;

    assign src1  = bus.ex_src1_i;
    assign src2  = bus.ex_src2_i;
    assign shamt = src2[4:0];
    assign kill  = rst | flush;

    assign is_arith    = (bus.ex_rtltype_i == `RTLTYPE_ARICH);
    assign arith_legal = (bus.ex_rtlop_i <= `RTLOP_MULHU);
    assign is_div_op   = (bus.ex_rtltype_i == `RTLTYPE_MULDIV) &&
                         ((bus.ex_rtlop_i == `RTLOP_DIV) || (bus.ex_rtlop_i == `RTLOP_DIVU) ||
                          (bus.ex_rtlop_i == `RTLOP_REM) || (bus.ex_rtlop_i == `RTLOP_REMU));
    assign div_signed  = (bus.ex_rtlop_i == `RTLOP_DIV) || (bus.ex_rtlop_i == `RTLOP_REM);
    assign div_is_rem  = (bus.ex_rtlop_i == `RTLOP_REM) || (bus.ex_rtlop_i == `RTLOP_REMU);
    assign div_req     = bus.ex_valid & is_div_op;

    // ------------------------------------------------------------------
    // Single-cycle ALU and multiplier
    // ------------------------------------------------------------------
    // One 2*XLEN multiplier serves all four multiply ops: the operands are
    // sign- or zero-extended to 2*XLEN so the truncated product is exact.
    logic            mul_a_signed;
    logic            mul_b_signed;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   alu_res;

    assign mul_a_signed = (bus.ex_rtlop_i == `RTLOP_MULH) || (bus.ex_rtlop_i == `RTLOP_MULHSU);
    assign mul_b_signed = (bus.ex_rtlop_i == `RTLOP_MULH);
    assign mul_a    = {{XLEN{mul_a_signed & src1[XLEN-1]}}, src1};
    assign mul_b    = {{XLEN{mul_b_signed & src2[XLEN-1]}}, src2};
    assign mul_prod = mul_a * mul_b;

    always_comb begin
        alu_res = '0;
        case (bus.ex_rtlop_i)
            `RTLOP_ADD:    alu_res = src1 + src2;
            `RTLOP_SUB:    alu_res = src1 - src2;
            `RTLOP_AND:    alu_res = src1 & src2;
            `RTLOP_OR:     alu_res = src1 | src2;
            `RTLOP_XOR:    alu_res = src1 ^ src2;
            `RTLOP_SLL:    alu_res = src1 << shamt;
            `RTLOP_SRL:    alu_res = src1 >> shamt;
            `RTLOP_SRA:    alu_res = $signed(src1) >>> shamt;
            `RTLOP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            `RTLOP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
            `RTLOP_MUL:    alu_res = mul_prod[XLEN-1:0];
            `RTLOP_MULH,
            `RTLOP_MULHSU,
            `RTLOP_MULHU:  alu_res = mul_prod[2*XLEN-1:XLEN];
            default:       alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider: operand preparation
    // ------------------------------------------------------------------
    logic            src1_neg;
    logic            src2_neg;
    logic [XLEN-1:0] src1_mag;
    logic [XLEN-1:0] src2_mag;
    logic            div_by_zero;
    logic            div_ovf;

    assign src1_neg    = div_signed & src1[XLEN-1];
    assign src2_neg    = div_signed & src2[XLEN-1];
    assign src1_mag    = src1_neg ? (~src1 + XLEN'(1)) : src1;
    assign src2_mag    = src2_neg ? (~src2 + XLEN'(1)) : src2;
    assign div_by_zero = (src2 == '0);
    assign div_ovf     = div_signed && (src1 == INT_MIN) && (src2 == '1);

    // ------------------------------------------------------------------
    // Divider FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    div_state_t state_q;
    div_state_t state_d;
    logic [4:0] cnt_q;
    logic       stall_req;

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (div_req) begin
                    state_d = (div_by_zero || div_ovf) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall covers the latch cycle and every BUSY cycle; DONE presents the
    // result so ID/EX may advance. Reset/flush win over everything.
    always_comb begin
        stall_req = 1'b0;
        if (!kill) begin
            case (state_q)
                S_IDLE:  stall_req = div_req;
                S_BUSY:  stall_req = 1'b1;
                default: stall_req = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rem_q;      // partial remainder
    logic [XLEN-1:0] quo_q;      // dividend shifts out the top, quotient in the bottom
    logic [XLEN-1:0] dvsr_q;     // |divisor|
    logic            sign1_q;
    logic            sign2_q;
    logic            rem_sel_q;
    logic            special_q;  // div-by-zero / overflow: results are final as loaded

    // The shifted remainder needs XLEN+1 bits: with |divisor| above 2^(XLEN-1)
    // the doubled remainder can exceed XLEN bits before the trial subtract.
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    assign trial = {rem_q, quo_q[XLEN-1]};
    assign diff  = trial - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (kill) begin
            cnt_q     <= 5'd0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            special_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_req) begin
                        sign1_q   <= src1_neg;
                        sign2_q   <= src2_neg;
                        rem_sel_q <= div_is_rem;
                        dvsr_q    <= src2_mag;
                        special_q <= div_by_zero | div_ovf;
                        if (div_by_zero) begin
                            quo_q <= '1;
                            rem_q <= src1;
                        end else if (div_ovf) begin
                            quo_q <= INT_MIN;
                            rem_q <= '0;
                        end else begin
                            quo_q <= src1_mag;
                            rem_q <= '0;
                            cnt_q <= 5'd31;
                        end
                    end
                end
                S_BUSY: begin
                    // diff[XLEN] set means the trial went negative: restore.
                    quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                    rem_q <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
                    if (cnt_q != 5'd0) begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_res;

    assign quo_fix = (!special_q && (sign1_q ^ sign2_q)) ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix = (!special_q && sign1_q)             ? (~rem_q + XLEN'(1)) : rem_q;
    assign div_res = rem_sel_q ? rem_fix : quo_fix;

    // ------------------------------------------------------------------
    // Result select and outputs. Selection depends only on type/op, never
    // on stall_req, so no loop exists through the stall network.
    // ------------------------------------------------------------------
    logic            legal_op;
    logic [XLEN-1:0] wdata;
    logic            valid_o;

    assign legal_op = (is_arith & arith_legal) | is_div_op;

    always_comb begin
        wdata = '0;
        if (is_arith && arith_legal) begin
            wdata = alu_res;
        end else if (is_div_op) begin
            wdata = div_res;
        end
    end

    assign valid_o = bus.ex_valid & ~stall_req & ~kill;

    assign bus.ex_stall_req    = stall_req;
    assign bus.ex_valid_o      = valid_o;
    assign bus.ex_pc_o         = bus.ex_pc_i;
    assign bus.ex_gprs_waddr_o = bus.ex_gprs_waddr_i;
    assign bus.ex_gprs_we_o    = valid_o & (bus.ex_gprs_waddr_i != `REG_X0) & legal_op;
    assign bus.ex_gprs_wdata_o = wdata;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; consumes the ID/EX pipeline register outputs (ex_* bus) and drives the EX/MEM register and the forwarding network.
- Single-cycle ALU/multiply ops complete combinationally.
- DIV/DIVU/REM/REMU run on an iterative 1-bit-per-cycle restoring divider.
- While the divider runs, the block raises a stall request that freezes ID/EX and the upstream stages.

Parameters:
XLEN, 32, datapath width; must equal width of `DATA_BUS.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
flush  input  1  pipeline flush (same signal driving ID/EX)
ex_valid  input  1  instruction valid from ID/EX
ex_rtlop_i  input  `RTLOP_BUS  operation
ex_rtltype_i  input  `RTLTYPE_BUS  operation class
ex_pc_i  input  `DATA_BUS  instruction PC (passed through)
ex_src1_i  input  `DATA_BUS  operand 1
ex_src2_i  input  `DATA_BUS  operand 2
ex_gprs_waddr_i  input  `REG_BUS  destination register
ex_stall_req  output  1  hold ID/EX and upstream this cycle
ex_valid_o  output  1  result valid to EX/MEM
ex_pc_o  output  `DATA_BUS  PC passthrough
ex_gprs_we_o  output  1  register write enable (also forwarding)
ex_gprs_waddr_o  output  `REG_BUS  destination register
ex_gprs_wdata_o  output  `DATA_BUS  result

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Class `RTLTYPE_ARICH (combinational, same cycle):
  - Ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, MULH, MULHSU, MULHU.
  - Shift amount is src2[4:0].
  - MUL returns the low 32 bits of the product; MULH* return the high 32 bits of the 64-bit product, with signedness per op.
- Class `RTLTYPE_MULDIV with DIV/DIVU/REM/REMU uses the divider FSM. Other op/type combinations yield wdata=0 with we=0.
- Divider FSM states: IDLE, BUSY, DONE. Registers: 5-bit counter, 32-bit partial remainder, 32-bit quotient/dividend shift register, |divisor|, sign flags, op latch.
- IDLE, div op presented with ex_valid=1:
  - stall_req=1.
  - Latch magnitudes and signs (signed ops take two's-complement abs).
  - Divisor==0: load quotient=0xFFFFFFFF and remainder=src1; go to DONE.
  - Signed op with src1=0x80000000 and src2=0xFFFFFFFF: load quotient=0x80000000 and remainder=0; go to DONE.
  - Otherwise: counter=31; go to BUSY.
- BUSY:
  - stall_req=1.
  - Each cycle: shift {rem,dividend} left by 1, trial-subtract divisor, set quotient bit on non-negative.
  - At counter==0 go to DONE; else decrement.
- DONE:
  - stall_req=0; result driven this cycle.
  - Quotient sign = sign1^sign2. Remainder sign = sign1. Sign fix-ups are not applied to the special cases.
  - Next state is IDLE unconditionally.
- Latency: normal divide asserts stall for 33 cycles (1 IDLE + 32 BUSY); result is valid in the 34th cycle. Special cases stall for 1 cycle; result in the 2nd cycle.
- Output rules:
  - ex_valid_o = ex_valid & ~ex_stall_req & ~flush.
  - ex_gprs_we_o = ex_valid_o & (waddr != `REG_X0) & legal op.
  - waddr and pc pass through combinationally.
  - wdata is don't-care when ex_valid_o=0.
- Reset or flush (any state): FSM to IDLE, counter 0. In that cycle ex_stall_req=0, ex_valid_o=0, ex_gprs_we_o=0. Any partial division is discarded.
- ex_valid=0 in IDLE: no state change, stall_req=0.
- ex_valid dropping while BUSY never occurs, because stall holds ID/EX; only flush aborts a division.
- Back-to-back divides: the DONE→IDLE transition lets the next presented divide start on the following cycle. The same instruction re-held by ID/EX is recomputed with an identical result.
- No combinational path from ex_stall_req back into ALU result selection. stall_req depends only on FSM state, ex_valid, type and op.

Test Plan:
- ADD src1=3, src2=4, waddr=x5, ex_valid=1 → same cycle: valid_o=1, we=1, wdata=7, stall_req=0. Repeat with waddr=x0 → we=0.
- DIVU 100/7 → stall_req high 33 cycles, then wdata=14. REMU 100/7 → wdata=2.
- DIV 0xFFFFFF9C/7 → 0xFFFFFFF2. REM 0xFFFFFF9C/7 → 0xFFFFFFFE. Both results in cycle 34.
- DIVU 5/0 → 1 stall cycle, wdata=0xFFFFFFFF. REMU 5/0 → wdata=5.
- DIV 0x80000000/0xFFFFFFFF → 1 stall cycle, wdata=0x80000000. REM on the same operands → wdata=0.
- Start DIV, assert flush at BUSY cycle 10 → stall_req=0 and we=0 that cycle, FSM IDLE. A following ADD 1+1 → wdata=2 with no residual stall. Same check with rst mid-BUSY.
